// File: rtl/wsc_ctrl_pkg.sv
// Shared P1500 wrapper-control definitions: WIR geometry, instruction codes, WBR-select decode.
package wsc_pkg;

    localparam int WIR_W = 3;
    localparam logic [WIR_W-1:0] WIR_CAPT = 3'b001;

    localparam logic [WIR_W-1:0] WS_BYPASS  = 3'b000;
    localparam logic [WIR_W-1:0] WS_INTEST  = 3'b001;
    localparam logic [WIR_W-1:0] WS_EXTEST  = 3'b010;
    localparam logic [WIR_W-1:0] WS_PRELOAD = 3'b011;

    function automatic logic is_wbr_instr(input logic [WIR_W-1:0] code);
        return (code == WS_INTEST) || (code == WS_EXTEST) || (code == WS_PRELOAD);
    endfunction

endpackage

// File: rtl/wsc_ctrl_if.sv
// Serial-port strobes, WBR chain hookup and status of the wrapper control stage.
interface wsc_ctrl_if #(parameter int CNT_W = 8);
    import wsc_pkg::*;

    logic             wsi;
    logic             select_wir;
    logic             shift_wr;
    logic             capture_wr;
    logic             update_wr;
    logic             wbr_so;
    logic             wbr_si;
    logic             wbr_se;
    logic             wbr_he;
    logic             wso;
    logic [WIR_W-1:0] instr;
    logic [CNT_W-1:0] shift_cnt;

    modport master (
        output wsi, select_wir, shift_wr, capture_wr, update_wr, wbr_so,
        input  wbr_si, wbr_se, wbr_he, wso, instr, shift_cnt
    );

    modport slave (
        input  wsi, select_wir, shift_wr, capture_wr, update_wr, wbr_so,
        output wbr_si, wbr_se, wbr_he, wso, instr, shift_cnt
    );

endinterface

// File: rtl/wsc_ctrl_wir_reg.sv
// Wrapper Instruction Register: shift/capture stage plus update stage, shift > capture > update.
// One-cycle latency from strobe edge to register; no backpressure.
module wir_reg
    import wsc_pkg::*;
#(
    parameter logic [WIR_W-1:0] CAPT = WIR_CAPT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wsi,
    input  logic             select_wir,
    input  logic             shift_wr,
    input  logic             capture_wr,
    input  logic             update_wr,
    output logic [WIR_W-1:0] wir_sh,
    output logic [WIR_W-1:0] wir_up
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wir_sh <= '0;
            wir_up <= WS_BYPASS;
        end else if (select_wir) begin
            if (shift_wr) begin
                wir_sh <= {wsi, wir_sh[WIR_W-1:1]};
            end else if (capture_wr) begin
                wir_sh <= CAPT;
            end else if (update_wr) begin
                wir_up <= wir_sh;
            end
        end
    end

endmodule

// File: rtl/wsc_ctrl.sv
// P1500 wrapper serial control: WIR, WBY, WBR SE/HE decode and WSO mux; shift-cycle counter.
// Registers update on the strobe edge, WBR controls and WSO are combinational; no backpressure.
module wsc_ctrl
    import wsc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    wsc_ctrl_if.slave  bus
);

    logic [WIR_W-1:0] wir_sh;
    logic [WIR_W-1:0] wir_up;
    logic             wbr_sel;
    logic             wby;
    logic [CNT_W-1:0] cnt;
    logic             dr_shift;
    logic             dr_capture;

    wir_reg #(.CAPT(WIR_CAPT)) u_wir (
        .clk        (clk),
        .rst        (rst),
        .wsi        (bus.wsi),
        .select_wir (bus.select_wir),
        .shift_wr   (bus.shift_wr),
        .capture_wr (bus.capture_wr),
        .update_wr  (bus.update_wr),
        .wir_sh     (wir_sh),
        .wir_up     (wir_up)
    );

    // Illegal codes collapse onto BYPASS, which is also the only non-WBR legal code.
    assign wbr_sel   = is_wbr_instr(wir_up);
    assign bus.instr = wbr_sel ? wir_up : WS_BYPASS;

    assign dr_shift   = !bus.select_wir && bus.shift_wr;
    assign dr_capture = !bus.select_wir && !bus.shift_wr && bus.capture_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wby <= 1'b0;
            cnt <= '0;
        end else begin
            if (dr_shift) begin
                if (!wbr_sel) begin
                    wby <= bus.wsi;
                end
                if (cnt != '1) begin
                    cnt <= cnt + 1'b1;
                end
            end else if (dr_capture) begin
                if (!wbr_sel) begin
                    wby <= 1'b0;
                end
                cnt <= '0;
            end
        end
    end

    assign bus.shift_cnt = cnt;
    assign bus.wbr_si    = bus.wsi;
    assign bus.wbr_se    = dr_shift && wbr_sel;
    // Hold loop everywhere except functional pass-through and the WBR capture cycle.
    assign bus.wbr_he    = wbr_sel && !dr_capture;

    always_comb begin
        if (bus.select_wir) begin
            bus.wso = wir_sh[0];
        end else if (wbr_sel) begin
            bus.wso = bus.wbr_so;
        end else begin
            bus.wso = wby;
        end
    end

endmodule

// File: doc/wsc_ctrl.md
Name: wsc_ctrl

Overview:
- Wrapper serial control stage directly upstream of the boundary-register chain in the IEEE P1500 wrapper around s349.
- Holds a Wrapper Instruction Register (WIR) and a 1-bit Wrapper Bypass register (WBY).
- Decodes the active instruction plus the serial-port strobes into the SE/HE controls that every WBR cell consumes.
- Muxes the WIR, WBY or WBR chain onto WSO.

Parameters:
- WIR_W, 3, WIR width in bits.
- WIR_CAPT, 3'b001, pattern loaded into the WIR shift stage on a WIR capture.
- CNT_W, 8, width of the shift-cycle counter.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- wsi  in  1  wrapper serial input.
- select_wir  in  1  1 = strobes target the WIR; 0 = strobes target the register selected by the instruction.
- shift_wr  in  1  shift strobe.
- capture_wr  in  1  capture strobe.
- update_wr  in  1  update strobe.
- wbr_so  in  1  serial out of the last WBR cell (its CTO).
- wbr_si  out  1  serial in to the first WBR cell (its CTI).
- wbr_se  out  1  SE to all WBR cells.
- wbr_he  out  1  HE to all WBR cells.
- wso  out  1  wrapper serial output.
- instr  out  WIR_W  active (updated) instruction.
- shift_cnt  out  CNT_W  shift cycles since last capture on the selected data register.

Behaviour:
Instruction encodings:
- 3'b000 WS_BYPASS
- 3'b001 WS_INTEST
- 3'b010 WS_EXTEST
- 3'b011 WS_PRELOAD
- All other codes decode as WS_BYPASS.
- wbr_sel = active instruction is INTEST, EXTEST or PRELOAD.

Strobe priority:
- When several strobes are high in one cycle: shift > capture > update.
- Only the winning strobe acts.

WIR:
- Two stages: wir_sh (shift stage) and wir_up (active stage).
- All actions below require select_wir=1.
- Shift: wir_sh <= {wsi, wir_sh[WIR_W-1:1]}.
- Capture: wir_sh <= WIR_CAPT.
- Update: wir_up <= wir_sh.
- instr = wir_up after decode. A new instruction takes effect the cycle after the update edge.

WBY:
- Requires select_wir=0 and !wbr_sel.
- Shift: wby <= wsi.
- Capture: wby <= 0.

WBR controls (combinational, so the WBR flops act on the same edge as the strobe):
- wbr_si = wsi.
- wbr_se = shift_wr & !select_wir & wbr_sel.
- wbr_he = 0 when !wbr_sel (functional pass-through; the cells recapture CFI every cycle).
- wbr_he = 0 when wbr_sel & !select_wir & capture_wr & !shift_wr (capture cycle: cell loads CFI).
- wbr_he = 1 otherwise (cell hold loop CFO->CTO; outputs driven from the cell).

WSO (combinational):
- select_wir=1: wso = wir_sh[0].
- Else if wbr_sel: wso = wbr_so.
- Else: wso = wby.

shift_cnt:
- Cleared to 0 on any data-register capture (select_wir=0).
- Increments on each data-register shift and saturates at all-ones.
- Unchanged by WIR activity.

Reset (asynchronous, immediate):
- wir_sh=0, wir_up=WS_BYPASS, wby=0, shift_cnt=0.
- Resulting outputs: instr=0, wbr_se=0, wbr_he=0, wso=0 when select_wir=0 (wso=0 when select_wir=1).
- Reset asserted mid-shift abandons the shift. No strobe acts while rst=1.

Decomposition:
- Shared package wsc_pkg holds:
  - instruction constants WS_BYPASS, WS_INTEST, WS_EXTEST, WS_PRELOAD;
  - WIR_W and WIR_CAPT;
  - the function is_wbr_instr().
- Natural sub-module: wir_reg, the WIR shift/capture/update pair with its priority logic.
- WBY, the counter and the muxes stay in wsc_ctrl.

Test Plan:
- Reset: assert rst mid-sequence -> instr=000, wbr_se=0, wbr_he=0, shift_cnt=0 immediately, with no clock needed.
- Load INTEST: select_wir=1, shift wsi 1,0,0 over 3 cycles, then update -> instr=001 one cycle later; wbr_he=1 with strobes idle. Capture beforehand -> wso=1 (WIR_CAPT[0]).
- WBR capture/shift: instr=INTEST, select_wir=0, capture 1 cycle -> wbr_he=0 and wbr_se=0 that cycle, shift_cnt=0; then shift 4 cycles -> wbr_se=1, wbr_he=1, wso=wbr_so, shift_cnt=4.
- Bypass: instr=BYPASS, select_wir=0, shift wsi=1 -> wso=1 next cycle, wbr_se=0, wbr_he=0; capture -> wso=0.
- Priority and saturation: shift_wr and capture_wr high together -> shift only, counter increments; 300 shifts -> shift_cnt=255.
- Illegal code: update WIR with 3'b111 -> behaves as BYPASS: wbr_he=0, and wso follows wby.
